exec_mem_unit: RTL and testbench
================================

EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 SHALL have parameter DMEM_BYTES, default 1024, giving data-memory size in bytes (power of two).
REQ-002 SHALL have one clock and an asynchronous, active-low reset; all storage is clocked on the clk rising edge.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 a, b  input  32 each  ALU operands.
REQ-006 alu_op  input  4  ALU operation select.
REQ-007 alu_o  output  32  ALU result, combinational.
REQ-008 br_type  input  3  branch condition, equal to RV32I funct3.
REQ-009 op_code  input  7  instruction opcode, instr[6:0].
REQ-010 rs1_data, rs2_data  input  32 each  branch compare operands.
REQ-011 br_en  output  1  take branch/jump, combinational.
REQ-012 addr  input  32  data-memory byte address.
REQ-013 wr_data  input  32  store data.
REQ-014 mem_wr, mem_rd  input  1 each  store enable, load enable.
REQ-015 mask  input  3  access size/sign, equal to RV32I load/store funct3.
REQ-016 dmem_o  output  32  load data, combinational.

Function
REQ-017 alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass b (LUI); 11-15 output 0.
REQ-018 Add/sub wrap modulo 2^32; shifts use b[4:0] only; SLT signed, SLTU unsigned, result 0 or 1.
REQ-019 op_code 1100011: br_en per br_type: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 give 0.
REQ-020 op_code 1101111 (JAL) or 1100111 (JALR): br_en=1 regardless of br_type; any other opcode: br_en=0.
REQ-021 Memory byte-addressed, little-endian; effective byte index = addr mod DMEM_BYTES; multi-byte accesses wrap byte-wise modulo DMEM_BYTES; misaligned access allowed.
REQ-022 Store (mem_wr=1, rst high) at clk rising edge: mask 000 writes wr_data[7:0]; 001 writes [15:0]; 010 writes [31:0]; other masks write nothing.
REQ-023 Load (mem_rd=1): 000 sign-extended byte, 001 sign-extended half, 010 word, 100 zero-extended byte, 101 zero-extended half; other masks give 0.
REQ-024 mem_rd=0 forces dmem_o=0.
REQ-025 Read is asynchronous; with mem_rd and mem_wr both set, dmem_o shows pre-edge contents until the edge, then the new data.

Reset
REQ-026 rst low asynchronously clears every memory byte to 0 and blocks writes while asserted.
REQ-027 ALU and branch paths are purely combinational and unaffected by rst; dmem_o reads 0 during reset.
REQ-028 Reset deassertion mid-stream: first write accepted at the first rising edge with rst high.

Structure
REQ-029 Shared package SHALL hold alu_op codes, br_type codes, opcode constants (BRANCH, JAL, JALR) and mask codes.
REQ-030 One sub-module, dmem_core (byte array, write and read formatting), is natural; ALU and branch logic stay inline.

Verification
REQ-031 a=0x7FFFFFFF, b=1, alu_op=0 -> alu_o=0x80000000; alu_op=1 with a=0, b=1 -> 0xFFFFFFFF; alu_op=7, a=0x80000000, b=0x21 -> 0xC0000000.
REQ-032 alu_op=3, a=0xFFFFFFFF, b=1 -> 1; alu_op=4 same operands -> 0; alu_op=10, b=0x12345000 -> 0x12345000.
REQ-033 op_code=1100011, br_type=100, rs1=0xFFFFFFFF, rs2=0 -> br_en=1; br_type=110 same data -> 0; op_code=1101111 -> 1; op_code=0110011 -> 0.
REQ-034 Store word 0x80FF7F01 at addr 0x10, then load mask 000 @0x13 -> 0xFFFFFF80; 100 @0x13 -> 0x80; 001 @0x12 -> 0xFFFF80FF; 010 @0x10 -> 0x80FF7F01.
REQ-035 Store byte 0xAA at addr DMEM_BYTES+4 -> load byte at 4 returns 0xFFFFFFAA; halfword store at DMEM_BYTES-1 writes bytes DMEM_BYTES-1 and 0.
REQ-036 Write data, assert rst low mid-run -> all loads return 0; store attempted during reset ignored.

Source files
------------

// File: rtl/exec_mem_unit_pkg.sv
// Shared encodings for the execute/memory stage: ALU ops, branch conditions,
// opcodes and load/store size masks (all RV32I-aligned).
package exec_mem_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_type_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    MASK_B  = 3'b000,
    MASK_H  = 3'b001,
    MASK_W  = 3'b010,
    MASK_BU = 3'b100,
    MASK_HU = 3'b101
  } mask_e;

endpackage

// File: rtl/exec_mem_unit_if.sv
// Data-memory access bus: address, store data, enables, size mask and load data.
interface exec_mem_unit_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [2:0]  mask;
  logic [31:0] dmem_o;

  modport master (output addr, wr_data, mem_wr, mem_rd, mask, input dmem_o);
  modport slave  (input addr, wr_data, mem_wr, mem_rd, mask, output dmem_o);
endinterface

// File: rtl/exec_mem_unit_dmem_core.sv
// Byte-addressed little-endian data memory with async read, sized/signed load
// formatting, and address wrap modulo DMEM_BYTES on every byte lane.
module exec_mem_unit_dmem_core
  import exec_mem_unit_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  exec_mem_unit_if.slave  mem
);

  localparam int unsigned AW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

  logic [7:0]    bytes_q [DMEM_BYTES];
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   word;
  logic [31:0]   rd_data;

  // Lane indices wrap naturally in AW bits, giving byte-wise modulo addressing.
  assign idx0 = mem.addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

  generate
    if (AW < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem.addr[31:AW];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DMEM_BYTES; i++) bytes_q[i] <= '0;
    end else if (mem.mem_wr) begin
      case (mem.mask)
        MASK_B: bytes_q[idx0] <= mem.wr_data[7:0];
        MASK_H: begin
          bytes_q[idx0] <= mem.wr_data[7:0];
          bytes_q[idx1] <= mem.wr_data[15:8];
        end
        MASK_W: begin
          bytes_q[idx0] <= mem.wr_data[7:0];
          bytes_q[idx1] <= mem.wr_data[15:8];
          bytes_q[idx2] <= mem.wr_data[23:16];
          bytes_q[idx3] <= mem.wr_data[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word    = {bytes_q[idx3], bytes_q[idx2], bytes_q[idx1], bytes_q[idx0]};
    rd_data = '0;
    if (mem.mem_rd) begin
      case (mem.mask)
        MASK_B:  rd_data = {{24{word[7]}}, word[7:0]};
        MASK_H:  rd_data = {{16{word[15]}}, word[15:0]};
        MASK_W:  rd_data = word;
        MASK_BU: rd_data = {24'd0, word[7:0]};
        MASK_HU: rd_data = {16'd0, word[15:0]};
        default: rd_data = '0;
      endcase
    end
  end

  assign mem.dmem_o = rd_data;

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory stage: combinational ALU and branch resolution plus the data memory.
module exec_mem_unit
  import exec_mem_unit_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic [3:0]      alu_op,
  output logic [31:0]     alu_o,
  input  logic [2:0]      br_type,
  input  logic [6:0]      op_code,
  input  logic [31:0]     rs1_data,
  input  logic [31:0]     rs2_data,
  output logic            br_en,
  exec_mem_unit_if.slave  mem
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    alu_o = '0;
    case (alu_op)
      ALU_ADD:  alu_o = a + b;
      ALU_SUB:  alu_o = a - b;
      ALU_SLL:  alu_o = a << shamt;
      ALU_SLT:  alu_o = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: alu_o = {31'd0, a < b};
      ALU_XOR:  alu_o = a ^ b;
      ALU_SRL:  alu_o = a >> shamt;
      ALU_SRA:  alu_o = $unsigned($signed(a) >>> shamt);
      ALU_OR:   alu_o = a | b;
      ALU_AND:  alu_o = a & b;
      ALU_LUI:  alu_o = b;
      default:  alu_o = '0;
    endcase
  end

  always_comb begin
    br_en = 1'b0;
    case (op_code)
      OP_BRANCH: begin
        case (br_type)
          BR_EQ:   br_en = (rs1_data == rs2_data);
          BR_NE:   br_en = (rs1_data != rs2_data);
          BR_LT:   br_en = ($signed(rs1_data) <  $signed(rs2_data));
          BR_GE:   br_en = ($signed(rs1_data) >= $signed(rs2_data));
          BR_LTU:  br_en = (rs1_data <  rs2_data);
          BR_GEU:  br_en = (rs1_data >= rs2_data);
          default: br_en = 1'b0;
        endcase
      end
      OP_JAL, OP_JALR: br_en = 1'b1;
      default:         br_en = 1'b0;
    endcase
  end

  exec_mem_unit_dmem_core #(.DMEM_BYTES(DMEM_BYTES)) u_dmem (
    .clk (clk),
    .rst (rst),
    .mem (mem)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_exec_mem_unit;

  localparam int unsigned DB = 1024;

  typedef struct {
    int          kind;  // 0 alu_o, 1 br_en, 2 dmem_o
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  alu_op;
  logic [31:0] alu_o;
  logic [2:0]  br_type;
  logic [6:0]  op_code;
  logic [31:0] rs1_data, rs2_data;
  logic        br_en;

  exec_mem_unit_if bus ();

  exec_mem_unit #(.DMEM_BYTES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .alu_o    (alu_o),
    .br_type  (br_type),
    .op_code  (op_code),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .br_en    (br_en),
    .mem      (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] got;
      e   = sb.pop_front();
      got = (e.kind == 0) ? alu_o : (e.kind == 1) ? {31'd0, br_en} : bus.dmem_o;
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
      end
    end
  end

  task automatic push_exp(input int k, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic alu_chk(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    alu_op = op; a = x; b = y;
    push_exp(0, exp, nm);
  endtask

  task automatic br_chk(input logic [6:0] oc, input logic [2:0] bt, input logic [31:0] r1,
                        input logic [31:0] r2, input logic exp, input string nm);
    @(posedge clk); #1;
    op_code = oc; br_type = bt; rs1_data = r1; rs2_data = r2;
    push_exp(1, {31'd0, exp}, nm);
  endtask

  task automatic store(input logic [31:0] ad, input logic [31:0] d, input logic [2:0] m);
    @(posedge clk); #1;
    bus.addr = ad; bus.wr_data = d; bus.mask = m; bus.mem_wr = 1'b1; bus.mem_rd = 1'b0;
    @(posedge clk); #1;
    bus.mem_wr = 1'b0;
  endtask

  task automatic load_chk(input logic [31:0] ad, input logic [2:0] m, input logic [31:0] exp,
                          input string nm);
    @(posedge clk); #1;
    bus.mem_wr = 1'b0; bus.mem_rd = 1'b1; bus.addr = ad; bus.mask = m;
    push_exp(2, exp, nm);
  endtask

  initial begin
    rst = 1'b0;
    a = '0; b = '0; alu_op = '0;
    br_type = '0; op_code = '0; rs1_data = '0; rs2_data = '0;
    bus.addr = '0; bus.wr_data = '0; bus.mem_wr = 1'b0; bus.mem_rd = 1'b0; bus.mask = '0;

    // Reset state: memory reads zero, ALU still live
    load_chk(32'h10, 3'b010, 32'h0, "reset_load");
    alu_chk(4'd0, 32'd2, 32'd3, 32'd5, "alu_in_reset");
    @(posedge clk); #3 rst = 1'b1;

    // ALU
    alu_chk(4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, "add_wrap");
    alu_chk(4'd1,  32'h0,        32'h1,        32'hFFFFFFFF, "sub_wrap");
    alu_chk(4'd7,  32'h80000000, 32'h21,       32'hC0000000, "sra_b40");
    alu_chk(4'd3,  32'hFFFFFFFF, 32'h1,        32'h1,        "slt");
    alu_chk(4'd4,  32'hFFFFFFFF, 32'h1,        32'h0,        "sltu");
    alu_chk(4'd4,  32'h1,        32'hFFFFFFFF, 32'h1,        "sltu_true");
    alu_chk(4'd10, 32'hDEAD0000, 32'h12345000, 32'h12345000, "lui");
    alu_chk(4'd2,  32'h1,        32'h24,       32'h10,       "sll_b40");
    alu_chk(4'd6,  32'h80000000, 32'h1F,       32'h1,        "srl");
    alu_chk(4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
    alu_chk(4'd8,  32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, "or");
    alu_chk(4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
    alu_chk(4'd11, 32'h12345678, 32'h1,        32'h0,        "op11_zero");
    alu_chk(4'd15, 32'h12345678, 32'h1,        32'h0,        "op15_zero");

    // Branch
    br_chk(7'b1100011, 3'b100, 32'hFFFFFFFF, 32'h0, 1'b1, "blt");
    br_chk(7'b1100011, 3'b110, 32'hFFFFFFFF, 32'h0, 1'b0, "bltu");
    br_chk(7'b1101111, 3'b110, 32'hFFFFFFFF, 32'h0, 1'b1, "jal");
    br_chk(7'b0110011, 3'b100, 32'hFFFFFFFF, 32'h0, 1'b0, "non_branch");
    br_chk(7'b1100111, 3'b010, 32'h0,        32'h5, 1'b1, "jalr");
    br_chk(7'b1100011, 3'b000, 32'h5,        32'h5, 1'b1, "beq");
    br_chk(7'b1100011, 3'b001, 32'h5,        32'h5, 1'b0, "bne");
    br_chk(7'b1100011, 3'b101, 32'h0,        32'hFFFFFFFF, 1'b1, "bge");
    br_chk(7'b1100011, 3'b111, 32'h0,        32'hFFFFFFFF, 1'b0, "bgeu");
    br_chk(7'b1100011, 3'b010, 32'h5,        32'h5, 1'b0, "bt010_zero");

    // Memory formatting
    store(32'h10, 32'h80FF7F01, 3'b010);
    load_chk(32'h13, 3'b000, 32'hFFFFFF80, "lb_13");
    load_chk(32'h13, 3'b100, 32'h00000080, "lbu_13");
    load_chk(32'h12, 3'b001, 32'hFFFF80FF, "lh_12");
    load_chk(32'h12, 3'b101, 32'h000080FF, "lhu_12");
    load_chk(32'h10, 3'b010, 32'h80FF7F01, "lw_10");
    load_chk(32'h11, 3'b010, 32'h0080FF7F, "lw_misaligned");
    load_chk(32'h10, 3'b011, 32'h0,        "ld_mask011_zero");
    @(posedge clk); #1;
    bus.mem_rd = 1'b0; bus.mask = 3'b010;
    push_exp(2, 32'h0, "rd_off_zero");

    // Wrap-around
    store(32'(DB + 4), 32'h000000AA, 3'b000);
    load_chk(32'h4, 3'b000, 32'hFFFFFFAA, "sb_wrap");
    store(32'(DB - 1), 32'h1234BEEF, 3'b001);
    load_chk(32'(DB - 1), 3'b100, 32'h000000EF, "sh_wrap_hi");
    load_chk(32'h0,       3'b100, 32'h000000BE, "sh_wrap_lo");
    load_chk(32'(DB - 1), 3'b101, 32'h0000BEEF, "lhu_wrap");
    load_chk(32'h1,       3'b100, 32'h00000000, "sh_no_spill");

    // Masks that store nothing
    store(32'h20, 32'hFFFFFFFF, 3'b011);
    store(32'h20, 32'hFFFFFFFF, 3'b100);
    load_chk(32'h20, 3'b010, 32'h0, "st_bad_mask");

    // Read-during-write: old data before the edge, new data after
    @(posedge clk); #1;
    bus.addr = 32'h10; bus.mask = 3'b010; bus.wr_data = 32'h11223344;
    bus.mem_rd = 1'b1; bus.mem_wr = 1'b1;
    push_exp(2, 32'h80FF7F01, "rdw_old");
    @(posedge clk); #1;
    bus.mem_wr = 1'b0;
    push_exp(2, 32'h11223344, "rdw_new");

    // Mid-run reset clears memory and blocks writes
    @(posedge clk); #1;
    rst = 1'b0;
    bus.addr = 32'h10; bus.mask = 3'b010; bus.wr_data = 32'hDEADBEEF;
    bus.mem_rd = 1'b1; bus.mem_wr = 1'b1;
    push_exp(2, 32'h0, "rst_clears");
    @(posedge clk); #1;
    push_exp(2, 32'h0, "rst_blocks_wr");
    bus.mem_wr = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    load_chk(32'h10, 3'b010, 32'h0, "post_rst_10");
    load_chk(32'h4,  3'b000, 32'h0, "post_rst_4");

    // First write accepted at the first rising edge after deassertion
    @(posedge clk); #1;
    rst = 1'b0;
    bus.addr = 32'h40; bus.mask = 3'b010; bus.wr_data = 32'hCAFEF00D;
    bus.mem_rd = 1'b1; bus.mem_wr = 1'b1;
    push_exp(2, 32'h0, "rst_hold_wr");
    @(posedge clk); #3 rst = 1'b1;
    push_exp(2, 32'h0, "before_first_edge");
    @(posedge clk); #1;
    bus.mem_wr = 1'b0;
    push_exp(2, 32'hCAFEF00D, "first_edge_wr");

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
